// File: rtl/qpsk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// qpsk_ctrl_pkg
//   Shared definitions for the QPSK receive-phase controller:
//     - sweep_state_e : encoding of the phase-sweep state machine
//     - DEF_*         : default values for the controller parameters
//     - SETTLE_CNT_W  : width of the settle counter (large enough for 255)
//     - LAST_PHASE    : highest trial phase of a sweep
// -----------------------------------------------------------------------------
package qpsk_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_COMPARE = 3'd3,
    ST_LOCKED  = 3'd4
  } sweep_state_e;

  localparam int DEF_WIN_LOG2 = 8;
  localparam int DEF_LATENCY  = 12;
  localparam int DEF_SETTLE   = 16;
  localparam int DEF_THRESH   = 4;

  localparam int SETTLE_CNT_W = 8;

  localparam logic [1:0] LAST_PHASE = 2'd3;

endpackage

// File: rtl/ber_compare.sv
// -----------------------------------------------------------------------------
// ber_compare
//   Aligns the transmitted reference bit with the demodulated bit and flags a
//   bit error. The reference is shifted into a LATENCY-deep delay line on each
//   symbol strobe; err is the XOR of rx_bit and the oldest delay-line entry, to
//   be sampled by the caller on the same strobe that shifts the line.
//
// Ports
//   clk     : system clock
//   rst     : synchronous active-high reset, clears the delay line
//   sym_en  : one-clk symbol strobe
//   ref_bit : transmitted PRBS bit
//   rx_bit  : demodulated bit
//   err     : rx_bit XOR reference delayed by LATENCY symbols
// -----------------------------------------------------------------------------
module ber_compare
  import qpsk_ctrl_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic sym_en,
  input  logic ref_bit,
  input  logic rx_bit,
  output logic err
);

  logic [LATENCY-1:0] dly_q;

  // A one-deep line has no lower slice to shift, so it is handled separately.
  if (LATENCY == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (rst) begin
        dly_q <= '0;
      end else if (sym_en) begin
        dly_q <= ref_bit;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (rst) begin
        dly_q <= '0;
      end else if (sym_en) begin
        dly_q <= {dly_q[LATENCY-2:0], ref_bit};
      end
    end
  end

  // dly_q[LATENCY-1] still holds the reference from LATENCY strobes ago at
  // the strobe edge, before the shift takes effect.
  assign err = rx_bit ^ dly_q[LATENCY-1];

endmodule

// File: rtl/phase_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// phase_sweep_ctrl
//   Sweeps the four receiver sampling phases, measures the bit-error count of
//   each over a window of 2^WIN_LOG2 symbols, then locks onto the phase with
//   the fewest errors (lowest phase wins ties). While locked it keeps measuring
//   back-to-back windows and restarts the sweep when a window exceeds THRESH.
//
// Ports
//   clk       : system clock, 4x the symbol rate
//   rst       : synchronous active-high reset
//   enable    : run the sweep / lock loop; low returns to idle
//   ref_bit   : transmitted PRBS bit
//   rx_bit    : demodulated bit
//   sym_en    : one-clk symbol strobe, period 4 clk, always running
//   phase_out : receiver sampling phase
//   locked    : high while the lock has been confirmed
//   err_count : error count of the last completed window
//   win_done  : one-clk pulse when err_count is updated
// -----------------------------------------------------------------------------
module phase_sweep_ctrl
  import qpsk_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = DEF_WIN_LOG2,
  parameter int LATENCY  = DEF_LATENCY,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int THRESH   = DEF_THRESH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                ref_bit,
  input  logic                rx_bit,
  output logic                sym_en,
  output logic [1:0]          phase_out,
  output logic                locked,
  output logic [WIN_LOG2:0]   err_count,
  output logic                win_done
);

  // One extra bit so a window with every symbol in error still fits.
  localparam int CNT_W = WIN_LOG2 + 1;

  // Symbol strobe generator
  logic [1:0] sym_cnt_q;
  logic       sym_en_q;

  // Sweep state
  sweep_state_e             state_q;
  logic [1:0]               phase_out_q;
  logic                     locked_q;
  logic [CNT_W-1:0]         err_count_q;
  logic                     win_done_q;
  logic [CNT_W-1:0]         best_err_q;
  logic [1:0]               best_phase_q;
  logic                     lock_pend_q;
  logic [SETTLE_CNT_W-1:0]  settle_cnt_q;
  logic [WIN_LOG2-1:0]      win_cnt_q;
  logic [CNT_W-1:0]         err_acc_q;

  // Next-value helpers
  logic                     err_bit;
  logic [CNT_W-1:0]         err_acc_d;
  logic                     better_d;
  logic [CNT_W-1:0]         best_err_d;
  logic [1:0]               best_phase_d;
  logic                     settle_last;
  logic                     win_last;
  logic                     over_thresh;

  // Strobe fires in the clk after the counter reads 1, so the first pulse
  // after reset appears two clks after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q <= 2'd0;
      sym_en_q  <= 1'b0;
    end else begin
      sym_cnt_q <= sym_cnt_q + 2'd1;
      sym_en_q  <= (sym_cnt_q == 2'd1);
    end
  end

  ber_compare #(
    .LATENCY (LATENCY)
  ) u_ber_compare (
    .clk     (clk),
    .rst     (rst),
    .sym_en  (sym_en_q),
    .ref_bit (ref_bit),
    .rx_bit  (rx_bit),
    .err     (err_bit)
  );

  assign err_acc_d   = err_acc_q + CNT_W'(err_bit);
  assign settle_last = (settle_cnt_q == SETTLE_CNT_W'(SETTLE - 1));
  assign win_last    = &win_cnt_q;
  assign over_thresh = (err_count_q > CNT_W'(THRESH));

  // Strict less-than keeps the earlier (lower) phase on a tie.
  assign better_d     = (err_count_q < best_err_q);
  assign best_err_d   = better_d ? err_count_q : best_err_q;
  assign best_phase_d = better_d ? phase_out_q : best_phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_out_q  <= 2'd0;
      locked_q     <= 1'b0;
      err_count_q  <= '0;
      win_done_q   <= 1'b0;
      best_err_q   <= '1;
      best_phase_q <= 2'd0;
      lock_pend_q  <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      err_acc_q    <= '0;
    end else if (!enable) begin
      // Abort whatever is in flight; the last reported count stays visible.
      state_q      <= ST_IDLE;
      phase_out_q  <= 2'd0;
      locked_q     <= 1'b0;
      win_done_q   <= 1'b0;
      best_err_q   <= '1;
      best_phase_q <= 2'd0;
      lock_pend_q  <= 1'b0;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      err_acc_q    <= '0;
    end else begin
      win_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q      <= ST_SETTLE;
          phase_out_q  <= 2'd0;
          best_err_q   <= '1;
          best_phase_q <= 2'd0;
          lock_pend_q  <= 1'b0;
          settle_cnt_q <= '0;
        end

        ST_SETTLE: begin
          if (sym_en_q) begin
            if (settle_last) begin
              settle_cnt_q <= '0;
              win_cnt_q    <= '0;
              err_acc_q    <= '0;
              // The final settle of a sweep leads into lock, not a trial.
              state_q      <= lock_pend_q ? ST_LOCKED : ST_MEASURE;
              locked_q     <= lock_pend_q;
              lock_pend_q  <= 1'b0;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
        end

        ST_MEASURE: begin
          if (sym_en_q) begin
            if (win_last) begin
              err_count_q <= err_acc_d;
              win_done_q  <= 1'b1;
              err_acc_q   <= '0;
              win_cnt_q   <= '0;
              state_q     <= ST_COMPARE;
            end else begin
              err_acc_q   <= err_acc_d;
              win_cnt_q   <= win_cnt_q + 1'b1;
            end
          end
        end

        ST_COMPARE: begin
          best_err_q   <= best_err_d;
          best_phase_q <= best_phase_d;
          settle_cnt_q <= '0;
          state_q      <= ST_SETTLE;
          if (phase_out_q != LAST_PHASE) begin
            phase_out_q <= phase_out_q + 2'd1;
          end else begin
            phase_out_q <= best_phase_d;
            lock_pend_q <= 1'b1;
          end
        end

        ST_LOCKED: begin
          if (sym_en_q) begin
            if (win_last) begin
              err_count_q <= err_acc_d;
              win_done_q  <= 1'b1;
              err_acc_q   <= '0;
              win_cnt_q   <= '0;
            end else begin
              err_acc_q   <= err_acc_d;
              win_cnt_q   <= win_cnt_q + 1'b1;
            end
          end else if (win_done_q && over_thresh) begin
            // Judged one clk after the window closes, from the latched count;
            // a strobe can never coincide with win_done_q.
            state_q      <= ST_SETTLE;
            locked_q     <= 1'b0;
            phase_out_q  <= 2'd0;
            best_err_q   <= '1;
            best_phase_q <= 2'd0;
            lock_pend_q  <= 1'b0;
            settle_cnt_q <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sym_en    = sym_en_q;
  assign phase_out = phase_out_q;
  assign locked    = locked_q;
  assign err_count = err_count_q;
  assign win_done  = win_done_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
module tb_phase_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ref_bit;
  logic       rx_bit;
  logic       sym_en;
  logic [1:0] phase_out;
  logic       locked;
  logic [8:0] err_count;
  logic       win_done;

  int n_vec  = 0;
  int n_miss = 0;

  // Loopback model state
  logic [11:0] hist;          // hist[11] = reference sent 12 strobes ago
  int unsigned sc;            // strobe counter of the model
  int          mode;          // 0: exact only at phase 2, 1: exact everywhere
  int          inj_left;      // extra errors still to inject

  always #5 clk = ~clk;

  phase_sweep_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .ref_bit   (ref_bit),
    .rx_bit    (rx_bit),
    .sym_en    (sym_en),
    .phase_out (phase_out),
    .locked    (locked),
    .err_count (err_count),
    .win_done  (win_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and drive the symbol the coming edge samples.
  // Phase 0 inverts every symbol (256 errors/window), phase 1 every other
  // (128), phase 3 every fourth (64), phase 2 is exact.
  task automatic step();
    logic flip;
    @(negedge clk);
    if (rst) begin
      hist = '0;
    end else if (sym_en) begin
      flip = 1'b0;
      if (mode == 0) begin
        case (phase_out)
          2'd0:    flip = 1'b1;
          2'd1:    flip = sc[0];
          2'd3:    flip = (sc % 4 == 0);
          default: flip = 1'b0;
        endcase
      end
      if (inj_left > 0) begin
        flip = ~flip;
        inj_left--;
      end
      rx_bit  = hist[11] ^ flip;
      ref_bit = 1'($urandom_range(0, 1));
      hist    = {hist[10:0], ref_bit};
      sc++;
    end
  endtask

  task automatic wait_wd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      step();
      if (win_done) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 1);
  endtask

  // Start from IDLE at a negedge; expect lock after 4*(16+256)+16 strobes.
  task automatic run_sweep(input logic [1:0] exp_ph,
                           input logic [8:0] e0, input logic [8:0] e1,
                           input logic [8:0] e2, input logic [8:0] e3);
    logic [8:0] exp_e [4];
    int n;
    int wd;
    bit seen;
    exp_e = '{e0, e1, e2, e3};
    n = 0;
    wd = 0;
    seen = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6000 && !seen; i++) begin
      step();
      if (locked) begin
        seen = 1'b1;
      end else begin
        if (win_done) begin
          if (wd < 4) begin
            chk("sweep_phase", 32'(phase_out), 32'(wd));
            chk("sweep_err", 32'(err_count), 32'(exp_e[wd]));
          end
          wd++;
        end
        n += int'(sym_en);
      end
    end
    chk("lock_seen", 32'(seen), 1);
    chk("lock_syms", 32'(n), 1104);
    chk("lock_windows", 32'(wd), 4);
    chk("lock_phase", 32'(phase_out), 32'(exp_ph));
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    enable = 1'b0;
    ref_bit = 1'b0;
    rx_bit = 1'b0;
    hist = '0;
    sc = 0;
    mode = 0;
    inj_left = 0;

    // Reset for 3 clk, then strobe cadence
    repeat (3) @(posedge clk);
    step();
    chk("rst_sym_en", 32'(sym_en), 0);
    chk("rst_phase", 32'(phase_out), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_win_done", 32'(win_done), 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("sym_en_cadence", 32'(sym_en), 32'(k % 4 == 2));
      chk("idle_locked", 32'(locked), 0);
    end

    // Loopback sweep: exact only at phase 2
    mode = 0;
    run_sweep(2'd2, 9'd256, 9'd128, 9'd0, 9'd64);

    // Locked windows: clean, then exactly THRESH errors, then THRESH+1
    wait_wd("lock_w0");
    chk("lock_w0_err", 32'(err_count), 0);
    chk("lock_w0_locked", 32'(locked), 1);
    inj_left = 4;
    wait_wd("lock_w4");
    chk("lock_w4_err", 32'(err_count), 4);
    inj_left = 5;
    step();
    chk("lock_w4_hold", 32'(locked), 1);
    wait_wd("lock_w5");
    chk("lock_w5_err", 32'(err_count), 5);
    chk("lock_w5_locked_at_pulse", 32'(locked), 1);
    step();
    chk("unlock_locked", 32'(locked), 0);
    chk("unlock_phase", 32'(phase_out), 0);

    // Sweep restarts at phase 0
    wait_wd("resweep_w0");
    chk("resweep_err", 32'(err_count), 256);
    chk("resweep_phase", 32'(phase_out), 0);
    step();
    chk("resweep_next_phase", 32'(phase_out), 1);

    // Drop enable in the middle of the phase-1 window
    cnt = 0;
    for (int i = 0; i < (16 + 100) * 4; i++) begin
      step();
      cnt += int'(win_done);
    end
    chk("mid_measure_no_pulse", 32'(cnt), 0);
    enable = 1'b0;
    step();
    chk("drop_phase", 32'(phase_out), 0);
    chk("drop_locked", 32'(locked), 0);
    chk("drop_win_done", 32'(win_done), 0);
    chk("drop_err_kept", 32'(err_count), 256);
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      cnt += int'(win_done) + int'(locked);
    end
    chk("idle_quiet", 32'(cnt), 0);

    // All phases exact: tie resolves to phase 0
    mode = 1;
    run_sweep(2'd0, 9'd0, 9'd0, 9'd0, 9'd0);

    // Reset while locked
    rst = 1'b1;
    step();
    chk("lrst_sym_en", 32'(sym_en), 0);
    chk("lrst_phase", 32'(phase_out), 0);
    chk("lrst_locked", 32'(locked), 0);
    chk("lrst_err_count", 32'(err_count), 0);
    chk("lrst_win_done", 32'(win_done), 0);
    enable = 1'b0;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cnt += int'(win_done) + int'(locked);
    end
    chk("post_rst_quiet", 32'(cnt), 0);
    run_sweep(2'd0, 9'd0, 9'd0, 9'd0, 9'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/phase_sweep_ctrl.md
PHASE_SWEEP_CTRL -- requirements
Module: phase_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_LOG2, default 8, where the measurement window is 2^WIN_LOG2 symbols.
REQ-002 The block SHALL have parameter LATENCY, default 12: the symbol delay from prbs bit_out to rx rx_out, range 1..63.
REQ-003 The block SHALL have parameter SETTLE, default 16: symbols discarded after every phase change, range 1..255.
REQ-004 The block SHALL have parameter THRESH, default 4: the maximum window errors tolerated while locked.
REQ-005 Port clk, input, 1 bit: the single system clock (4x symbol rate).
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port enable, input, 1 bit: starts and keeps running the sweep; low means return to IDLE.
REQ-008 Port ref_bit, input, 1 bit: transmitted PRBS bit (prbs bit_out).
REQ-009 Port rx_bit, input, 1 bit: demodulated bit (rx rx_out).
REQ-010 Port sym_en, output, 1 bit: one-clk symbol strobe that drives the prbs clock/enable.
REQ-011 Port phase_out, output, 2 bits: drives rx phase_in.
REQ-012 Port locked, output, 1 bit: high while in LOCKED.
REQ-013 Port err_count, output, WIN_LOG2+1 bits: error count of the last completed window.
REQ-014 Port win_done, output, 1 bit: one-clk pulse when err_count updates.

Function
REQ-015 A free-running 2-bit counter SHALL increment every clk; sym_en SHALL be high only in the clk after the one where the counter equals 1, giving a period of exactly 4 clk.
REQ-016 On sym_en, ref_bit SHALL shift into a LATENCY-deep delay line; the error bit is rx_bit XOR delay_line[LATENCY-1], sampled on the same sym_en.
REQ-017 The FSM SHALL have the states IDLE, SETTLE, MEASURE, COMPARE and LOCKED.
REQ-018 IDLE: phase_out=0 and the counters are cleared; when enable=1, the FSM SHALL enter SETTLE with trial phase 0.
REQ-019 SETTLE: the FSM SHALL count SETTLE sym_en strobes, then enter MEASURE.
REQ-020 MEASURE: the FSM SHALL accumulate errors over 2^WIN_LOG2 sym_en strobes, then latch err_count, pulse win_done and enter COMPARE.
REQ-021 COMPARE (1 clk): if err < best_err, the block SHALL store best_err and best_phase; ties keep the lower phase. If trial phase < 3, it SHALL increment phase_out and enter SETTLE; otherwise it SHALL set phase_out=best_phase and enter SETTLE followed by LOCKED.
REQ-022 The best_err initial value for each sweep SHALL be all-ones.
REQ-023 LOCKED: the block SHALL measure continuous back-to-back windows at the locked phase; a window with err_count > THRESH SHALL clear locked and restart the sweep at phase 0 via SETTLE.
REQ-024 The error counter SHALL be WIN_LOG2+1 bits and cannot overflow, since the maximum count equals the window length.
REQ-025 enable=0 in any state SHALL force IDLE on the next clk: locked=0, phase_out=0, with err_count retained.
REQ-026 sym_en SHALL keep running regardless of enable or state.
REQ-027 A phase change SHALL appear on phase_out the clk after COMPARE, and the SETTLE count SHALL start from the next sym_en.

Reset
REQ-028 On rst=1 at a clk edge, the block SHALL be in state IDLE with the symbol counter=0, sym_en=0, phase_out=0, locked=0, err_count=0, win_done=0, and the delay line all 0.
REQ-029 Reset mid-sweep or mid-lock SHALL abort the sweep with no partial result retained.

Structure
REQ-030 The FSM state encoding and the default parameter constants SHALL live in the shared package qpsk_ctrl_pkg.
REQ-031 The reference delay line plus XOR SHALL be the sub-module ber_compare (parameter LATENCY; ports clk, rst, sym_en, ref_bit, rx_bit, err).

Verification
REQ-032 Scenario: rst for 3 clk, then release. Response: sym_en period is 4 clk with the first pulse at clk 2 after reset; all other outputs are 0.
REQ-033 Scenario: loopback model with rx_bit = ref_bit delayed 12 symbols, bit-exact only at phase 2 and random at other phases, WIN_LOG2=8. Response: four win_done pulses, then phase_out=2 and locked=1 after 4*(16+256) symbols plus 16 settle symbols.
REQ-034 Scenario: all phases error-free. Response: best_phase=0 (tie rule) and locked=1.
REQ-035 Scenario: locked, then inject 5 errors within one window. Response: locked falls, phase_out=0 the clk after that win_done, and the sweep restarts.
REQ-036 Scenario: enable dropped during MEASURE of phase 1. Response: next clk shows IDLE, phase_out=0, and no win_done pulse.
REQ-037 Scenario: rst asserted while LOCKED. Response: all outputs at reset values on the next clk, and re-sweep only after rst=0 and enable=1.
